rom_arbiter: RTL and testbench

Two-port arbiter that shares the single combinational program ROM (8-bit address, 16-bit data) between the instruction-fetch path and the data-load path. Each requester issues a req/addr handshake. The arbiter selects one requester per cycle by round-robin, drives the ROM address, and returns the ROM word one cycle later on the winning port's registered response bus. It sits between the CPU front end and `rom`, and is the only block allowed to drive the ROM address.

---
 rtl/rom_arbiter.sv | 122 ++++++++++++
 tb/tb_rom_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single combinational program ROM between the
// instruction-fetch port and the data-load port. One requester is granted
// per cycle (round-robin on conflict); the ROM word is returned one cycle
// later on the winner's registered response bus.
module rom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data
);

    // last_grant_r: 1'b0 = fetch won last, 1'b1 = data won last
    logic              last_grant_r;
    logic              f_gnt_s;
    logic              d_gnt_s;
    logic [ADDR_W-1:0] rom_address_s;
    logic              f_rvalid_r;
    logic              d_rvalid_r;
    logic [DATA_W-1:0] f_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    // Grant decision: a lone requester wins, a conflict goes to the port
    // that did not win last; nothing is granted while reset is held.
    always_comb begin
        f_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst) begin
            f_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (f_req && d_req) begin
            if (last_grant_r) begin
                f_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (f_req) begin
            f_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            f_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // ROM address mux: the winner's address, otherwise zero.
    always_comb begin
        rom_address_s = {ADDR_W{1'b0}};
        if (f_gnt_s) begin
            rom_address_s = f_addr;
        end else if (d_gnt_s) begin
            rom_address_s = d_addr;
        end else begin
            rom_address_s = {ADDR_W{1'b0}};
        end
    end

    // Round-robin history; idle cycles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (f_gnt_s) begin
            last_grant_r <= 1'b0;
        end else if (d_gnt_s) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Fetch response: valid exactly the cycle after a fetch grant; data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rvalid_r <= 1'b0;
            f_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            f_rvalid_r <= f_gnt_s;
            if (f_gnt_s) begin
                f_rdata_r <= rom_data;
            end else begin
                f_rdata_r <= f_rdata_r;
            end
        end
    end

    // Data-load response: valid exactly the cycle after a data grant; data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rvalid_r <= 1'b0;
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            d_rvalid_r <= d_gnt_s;
            if (d_gnt_s) begin
                d_rdata_r <= rom_data;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign f_gnt       = f_gnt_s;
    assign d_gnt       = d_gnt_s;
    assign rom_address = rom_address_s;
    assign f_rvalid    = f_rvalid_r;
    assign f_rdata     = f_rdata_r;
    assign d_rvalid    = d_rvalid_r;
    assign d_rdata     = d_rdata_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with a stub ROM returning {A5, address}.
// A behavioural model (winner choice + pending response per port) predicts
// grants, ROM address and responses.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req;
    logic [7:0]  f_addr, d_addr;
    logic        f_gnt, d_gnt, f_rvalid, d_rvalid;
    logic [15:0] f_rdata, d_rdata, rom_data;
    logic [7:0]  rom_address;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit          m_last;
    bit          m_fv, m_dv;
    logic [15:0] m_fd, m_dd;

    rom_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .rom_address(rom_address), .rom_data(rom_data)
    );

    assign rom_data = {8'hA5, rom_address};

    always #5 clk = ~clk;

    // expected {fetch_grant, data_grant} from the arbitration rules
    function automatic logic [1:0] arb(input logic f, input logic d, input bit last);
        if (f && d) return last ? 2'b10 : 2'b01;
        if (f) return 2'b10;
        if (d) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_last = 1'b1; m_fv = 1'b0; m_dv = 1'b0; m_fd = 16'h0000; m_dd = 16'h0000;
    endtask

    // apply requester inputs just after the falling edge
    task automatic drive(input logic f, input logic [7:0] fa, input logic d, input logic [7:0] da);
        @(negedge clk);
        f_req = f; f_addr = fa; d_req = d; d_addr = da;
        #1;
    endtask

    // rising edge: advance the model, then settle
    task automatic tick();
        logic [1:0] g;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            g = arb(f_req, d_req, m_last);
            m_fv = g[1];
            m_dv = g[0];
            if (g[1]) begin m_fd = {8'hA5, f_addr}; m_last = 1'b0; end
            if (g[0]) begin m_dd = {8'hA5, d_addr}; m_last = 1'b1; end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = 8'h00; d_addr = 8'h00;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h11, 1'b1, 8'h22);
        tick();
        checks++; if (f_rvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_f_rvalid: got %b expected 1", f_rvalid); end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", f_rvalid, d_rvalid); end
        checks++; if (f_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0000 0000", f_rdata, d_rdata); end
        checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0 || rom_address !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %b%b addr %h expected 00 addr 00", f_gnt, d_gnt, rom_address); end
        tick();
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_held: got rv %b%b gnt %b%b expected 0000", f_rvalid, d_rvalid, f_gnt, d_gnt); end
        @(negedge clk);
        rst = 1'b0;
        f_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_fetch_only();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 1'b0, 8'h00);
            checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || rom_address !== 8'(i)) begin errors++; $display("FAIL fetch_gnt[%0d]: got %b%b addr %h expected 10 addr %h", i, f_gnt, d_gnt, rom_address, 8'(i)); end
            tick();
            checks++; if (f_rvalid !== 1'b1 || f_rdata !== {8'hA5, 8'(i)} || d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_resp[%0d]: got %b %h d%b expected 1 %h d0", i, f_rvalid, f_rdata, d_rvalid, {8'hA5, 8'(i)}); end
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== 16'hA509) begin errors++; $display("FAIL fetch_hold: got %b %h expected 0 a509", f_rvalid, f_rdata); end
    endtask

    task automatic test_conflict_after_reset();
        do_reset();
        drive(1'b1, 8'h03, 1'b1, 8'h07);
        checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || rom_address !== 8'h03) begin errors++; $display("FAIL conflict_c0: got %b%b addr %h expected 10 addr 03", f_gnt, d_gnt, rom_address); end
        tick();
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 16'hA503) begin errors++; $display("FAIL conflict_f_resp: got %b %h expected 1 a503", f_rvalid, f_rdata); end
        drive(1'b1, 8'h04, 1'b1, 8'h07);
        checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b1 || rom_address !== 8'h07) begin errors++; $display("FAIL conflict_c1: got %b%b addr %h expected 01 addr 07", f_gnt, d_gnt, rom_address); end
        tick();
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 16'hA507 || f_rvalid !== 1'b0) begin errors++; $display("FAIL conflict_d_resp: got %b %h f%b expected 1 a507 f0", d_rvalid, d_rdata, f_rvalid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  fa, da;
        logic [15:0] fq[$], dq[$];
        int fresp, dresp;
        fa = 8'h40; da = 8'h80; fresp = 0; dresp = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1'b1, fa, 1'b1, da);
            else drive(1'b0, 8'h00, 1'b0, 8'h00);
            if (i < 8) begin
                checks++; if (f_gnt !== ((i % 2) == 0) || d_gnt !== ((i % 2) == 1)) begin errors++; $display("FAIL contention_order[%0d]: got %b%b expected %b%b", i, f_gnt, d_gnt, (i % 2) == 0, (i % 2) == 1); end
                if ((i % 2) == 0) fq.push_back({8'hA5, fa}); else dq.push_back({8'hA5, da});
            end
            if (f_gnt) fa = fa + 8'h01;
            if (d_gnt) da = da + 8'h01;
            tick();
            if (f_rvalid) begin
                fresp++;
                checks++;
                if (fq.size() == 0) begin errors++; $display("FAIL contention_f_extra: got %h expected none", f_rdata); end
                else if (f_rdata !== fq[0]) begin errors++; $display("FAIL contention_f_data: got %h expected %h", f_rdata, fq[0]); end
                if (fq.size() != 0) void'(fq.pop_front());
            end
            if (d_rvalid) begin
                dresp++;
                checks++;
                if (dq.size() == 0) begin errors++; $display("FAIL contention_d_extra: got %h expected none", d_rdata); end
                else if (d_rdata !== dq[0]) begin errors++; $display("FAIL contention_d_data: got %h expected %h", d_rdata, dq[0]); end
                if (dq.size() != 0) void'(dq.pop_front());
            end
        end
        checks++; if (fresp != 4 || dresp != 4) begin errors++; $display("FAIL contention_count: got %0d/%0d expected 4/4", fresp, dresp); end
    endtask

    task automatic test_gap();
        do_reset();
        drive(1'b1, 8'h10, 1'b0, 8'h00);
        tick();
        repeat (2) begin
            drive(1'b0, 8'h00, 1'b0, 8'h00);
            checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0 || rom_address !== 8'h00) begin errors++; $display("FAIL gap_idle: got %b%b addr %h expected 00 addr 00", f_gnt, d_gnt, rom_address); end
            tick();
        end
        drive(1'b1, 8'h11, 1'b1, 8'h31);
        checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b1) begin errors++; $display("FAIL gap_history_kept: got %b%b expected 01", f_gnt, d_gnt); end
        tick();
        repeat (2) begin drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); end
        drive(1'b0, 8'h00, 1'b1, 8'h30);
        checks++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || rom_address !== 8'h30) begin errors++; $display("FAIL gap_d_only: got %b%b addr %h expected 01 addr 30", f_gnt, d_gnt, rom_address); end
        tick();
        repeat (2) begin drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); end
        drive(1'b1, 8'h12, 1'b1, 8'h32);
        checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL gap_conflict: got %b%b expected 10", f_gnt, d_gnt); end
        tick();
    endtask

    task automatic test_reset_mid_response();
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h20);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %b expected 1", d_gnt); end
        tick();
        #2;
        rst = 1'b1;
        f_req = 1'b0; d_req = 1'b0;
        model_reset();
        #1;
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 16'h0000) begin errors++; $display("FAIL midrst_drop: got %b %h expected 0 0000", d_rvalid, d_rdata); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h01, 1'b1, 8'h02);
        checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL midrst_conflict: got %b%b expected 10", f_gnt, d_gnt); end
        tick();
    endtask

    task automatic test_random();
        logic       fr, dr;
        logic [7:0] fa, da, ea;
        logic [1:0] e;
        int fw, dw;
        fr = 1'b0; dr = 1'b0; fa = 8'h00; da = 8'h00; fw = 0; dw = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            // a requester still waiting keeps req/addr; otherwise pick anew
            if (!(fr && fw > 0)) begin fr = ($urandom % 3) != 0; fa = 8'($urandom); end
            if (!(dr && dw > 0)) begin dr = ($urandom % 3) != 0; da = 8'($urandom); end
            drive(fr, fa, dr, da);
            e  = arb(fr, dr, m_last);
            ea = e[1] ? fa : (e[0] ? da : 8'h00);
            checks++; if (f_gnt !== e[1] || d_gnt !== e[0] || rom_address !== ea) begin errors++; $display("FAIL rand_gnt[%0d]: got %b%b addr %h expected %b%b addr %h", i, f_gnt, d_gnt, rom_address, e[1], e[0], ea); end
            fw = (fr && !f_gnt) ? fw + 1 : 0;
            dw = (dr && !d_gnt) ? dw + 1 : 0;
            checks++; if (fw > 1 || dw > 1) begin errors++; $display("FAIL rand_starve[%0d]: got waits %0d/%0d expected <=1", i, fw, dw); end
            tick();
            checks++; if (f_rvalid !== m_fv || d_rvalid !== m_dv || f_rdata !== m_fd || d_rdata !== m_dd) begin errors++; $display("FAIL rand_resp[%0d]: got %b %h %b %h expected %b %h %b %h", i, f_rvalid, f_rdata, d_rvalid, d_rdata, m_fv, m_fd, m_dv, m_dd); end
            if (fw == 0 && !f_gnt) fr = 1'b0;
            if (dw == 0 && !d_gnt) dr = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = 8'h00; d_addr = 8'h00;
        model_reset();
        #1;
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin errors++; $display("FAIL power_on_reset: got %b%b %h %h expected 00 0000 0000", f_rvalid, d_rvalid, f_rdata, d_rdata); end
        test_reset();
        test_fetch_only();
        test_conflict_after_reset();
        test_back_to_back();
        test_gap();
        test_reset_mid_response();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
